// File: rtl/pipelined_alu_core.sv
// Three-stage (D/E/W) integer ALU with a 32-entry register file, valid/ready on
// both sides, RAW hazards resolved by stalling in D until the producer writes back.
module pipelined_alu_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic [31:0]           i_instr,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_ready1,
  output logic [DATA_WIDTH-1:0] o_data1,
  output logic                  o_valid1
);

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] dst;
    logic [4:0] s1;
    logic [4:0] s2;
  } d_t;

  typedef struct packed {
    logic [1:0]            op;
    logic [4:0]            dst;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } e_t;

  logic [DATA_WIDTH-1:0] r_rf [32];
  d_t                    r_d;
  e_t                    r_e;
  logic [4:0]            r_w_dst;
  logic [DATA_WIDTH-1:0] r_w_res;
  logic                  r_d_vld, r_e_vld, r_w_vld;

  logic                  w_adv, w_e2w, w_d2e, w_haz, w_acc, w_wb;
  logic [DATA_WIDTH-1:0] w_alu;
  d_t                    w_dec;
  logic                  w_unused;

  assign w_dec    = d_t'(i_instr[31:15]);
  assign w_unused = ^i_instr[14:0];

  assign w_adv = !r_w_vld | i_ready1;
  assign w_e2w = r_e_vld & w_adv;
  // Both E and W dests count: a W result is not in the register file until it transfers.
  assign w_haz = (r_e_vld & ((r_e.dst == r_d.s1) | (r_e.dst == r_d.s2))) |
                 (r_w_vld & ((r_w_dst == r_d.s1) | (r_w_dst == r_d.s2)));
  assign w_d2e = r_d_vld & !w_haz & (!r_e_vld | w_adv);
  assign w_acc = i_valid & o_ready;
  assign w_wb  = r_w_vld & i_ready1;

  assign o_ready  = !r_d_vld | w_d2e;
  assign o_valid1 = r_w_vld;
  assign o_data1  = r_w_res;

  always_comb begin
    w_alu = '0;
    case (r_e.op)
      2'b00:   w_alu = r_e.a + r_e.b;
      2'b01:   w_alu = r_e.a - r_e.b;
      2'b10:   w_alu = r_e.a & r_e.b;
      default: w_alu = r_e.a | r_e.b;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_d_vld <= 1'b0;
      r_e_vld <= 1'b0;
      r_w_vld <= 1'b0;
      r_d     <= '0;
      r_e     <= '0;
      r_w_dst <= '0;
      r_w_res <= '0;
    end else begin
      if (w_acc) begin
        r_d     <= w_dec;
        r_d_vld <= 1'b1;
      end else if (w_d2e) begin
        r_d_vld <= 1'b0;
      end

      if (w_d2e) begin
        r_e.op  <= r_d.op;
        r_e.dst <= r_d.dst;
        r_e.a   <= r_rf[r_d.s1];
        r_e.b   <= r_rf[r_d.s2];
        r_e_vld <= 1'b1;
      end else if (w_e2w) begin
        r_e_vld <= 1'b0;
      end

      if (w_e2w) begin
        r_w_dst <= r_e.dst;
        r_w_res <= w_alu;
        r_w_vld <= 1'b1;
      end else if (w_wb) begin
        r_w_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= DATA_WIDTH'(5 * i);
    end else if (w_wb) begin
      r_rf[r_w_dst] <= r_w_res;
    end
  end

endmodule

// File: tb/tb_pipelined_alu_core.sv
// Directed bench for pipelined_alu_core: latency, hazard stall, backpressure,
// throughput and asynchronous reset, each scenario checked with hand-computed values.
module tb_pipelined_alu_core;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   instr;
  logic          vld;
  logic          rdy;
  logic          rdy1;
  logic [DW-1:0] data1;
  logic          vld1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_alu_core #(.DATA_WIDTH(DW)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_instr(instr), .i_valid(vld),
    .o_ready(rdy), .i_ready1(rdy1), .o_data1(data1), .o_valid1(vld1)
  );

  function automatic logic [31:0] mk(input logic [1:0] op, input int d, input int s1, input int s2);
    mk = {op, 5'(d), 5'(s1), 5'(s2), 15'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    instr = ins;
    vld   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vld = 1'b0; instr = '0; rdy1 = 1'b1;
    #3;
    n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL reset_vld1 got %b exp 0", vld1); end
    n_vec++; if (data1 !== 8'd0) begin n_err++; $display("FAIL reset_data1 got %0d exp 0", data1); end
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", rdy); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ADD R3,R1,R2: result visible from just after acceptance edge + 2, for one cycle
  task automatic test_latency();
    rdy1 = 1'b1;
    issue(mk(2'b00, 3, 1, 2));
    tick(); vld = 1'b0;
    n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL lat_n0 vld1 got %b exp 0", vld1); end
    tick();
    n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL lat_n1 vld1 got %b exp 0", vld1); end
    tick();
    n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd15) begin n_err++; $display("FAIL lat_n2 got vld=%b data=%0d exp vld=1 data=15", vld1, data1); end
    tick();
    n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL lat_n3 vld1 got %b exp 0", vld1); end
  endtask

  // ADD R3,R1,R2 then SUB R4,R3,R2: SUB waits in D until ADD writes back
  task automatic test_hazard();
    rdy1 = 1'b1;
    issue(mk(2'b00, 3, 1, 2));
    tick();
    issue(mk(2'b01, 4, 3, 2)); #1;
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL haz_accept_rdy got %b exp 1", rdy); end
    tick(); vld = 1'b0;
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL haz_stall_e rdy got %b exp 0", rdy); end
    tick();
    n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd15 || rdy !== 1'b0) begin n_err++; $display("FAIL haz_add_out got vld=%b data=%0d rdy=%b exp 1/15/0", vld1, data1, rdy); end
    tick();
    n_vec++; if (vld1 !== 1'b0 || rdy !== 1'b1) begin n_err++; $display("FAIL haz_bubble1 got vld=%b rdy=%b exp 0/1", vld1, rdy); end
    tick();
    n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL haz_bubble2 vld1 got %b exp 0", vld1); end
    tick();
    n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd5) begin n_err++; $display("FAIL haz_sub_out got vld=%b data=%0d exp 1/5", vld1, data1); end
    tick();
    n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL haz_drain vld1 got %b exp 0", vld1); end
  endtask

  // AND R5,R1,R2 held under backpressure, then writeback checked via OR R10,R5,R0
  task automatic test_backpressure();
    rdy1 = 1'b0;
    issue(mk(2'b10, 5, 1, 2));
    tick(); vld = 1'b0;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd0) begin n_err++; $display("FAIL bp_hold%0d got vld=%b data=%0d exp 1/0", k, vld1, data1); end
      if (k < 3) tick();
    end
    rdy1 = 1'b1;
    tick();
    n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL bp_once vld1 got %b exp 0", vld1); end
    issue(mk(2'b11, 10, 5, 0));
    tick(); vld = 1'b0;
    tick(); tick();
    n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd0) begin n_err++; $display("FAIL bp_r5_wb got vld=%b data=%0d exp 1/0", vld1, data1); end
    tick();
  endtask

  // four independent instructions under backpressure: at most three in flight, in-order drain
  task automatic test_fill_drain();
    logic [31:0] prog [4];
    logic [7:0]  exp_r [4];
    prog[0] = mk(2'b11, 6, 1, 2);  exp_r[0] = 8'd15;
    prog[1] = mk(2'b01, 13, 2, 1); exp_r[1] = 8'd5;
    prog[2] = mk(2'b10, 14, 2, 2); exp_r[2] = 8'd10;
    prog[3] = mk(2'b00, 15, 1, 1); exp_r[3] = 8'd10;
    rdy1 = 1'b0;
    for (int k = 0; k < 3; k++) begin issue(prog[k]); tick(); end
    issue(prog[3]); #1;
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL fill_full rdy got %b exp 0", rdy); end
    tick();
    n_vec++; if (rdy !== 1'b0 || vld1 !== 1'b1 || data1 !== exp_r[0]) begin n_err++; $display("FAIL fill_hold got rdy=%b vld=%b data=%0d exp 0/1/15", rdy, vld1, data1); end
    rdy1 = 1'b1; #1;
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL fill_rdy_comb got %b exp 1", rdy); end
    tick(); vld = 1'b0;
    for (int k = 1; k < 4; k++) begin
      n_vec++; if (vld1 !== 1'b1 || data1 !== exp_r[k]) begin n_err++; $display("FAIL drain%0d got vld=%b data=%0d exp 1/%0d", k, vld1, data1, exp_r[k]); end
      tick();
    end
    n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL drain_end vld1 got %b exp 0", vld1); end
  endtask

  // ADD R7,R1,R1 then SUB R8,R2,R1: consecutive results, no bubble
  task automatic test_back_to_back();
    rdy1 = 1'b1;
    issue(mk(2'b00, 7, 1, 1)); tick();
    issue(mk(2'b01, 8, 2, 1)); tick();
    vld = 1'b0; tick();
    n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd10) begin n_err++; $display("FAIL b2b_first got vld=%b data=%0d exp 1/10", vld1, data1); end
    tick();
    n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd5) begin n_err++; $display("FAIL b2b_second got vld=%b data=%0d exp 1/5", vld1, data1); end
    tick();
    n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL b2b_end vld1 got %b exp 0", vld1); end
  endtask

  // R3 <- 20, then async reset with a result held in W; R3 must come back as 15
  task automatic test_async_reset();
    rdy1 = 1'b1;
    issue(mk(2'b00, 3, 2, 2)); tick();
    vld = 1'b0; tick(); tick();
    n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd20) begin n_err++; $display("FAIL ar_r3_20 got vld=%b data=%0d exp 1/20", vld1, data1); end
    tick();
    rdy1 = 1'b0;
    issue(mk(2'b00, 9, 1, 1)); tick();
    vld = 1'b0; tick(); tick();
    n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd10) begin n_err++; $display("FAIL ar_held got vld=%b data=%0d exp 1/10", vld1, data1); end
    #2 rst_n = 1'b0; #1;
    n_vec++; if (vld1 !== 1'b0 || data1 !== 8'd0 || rdy !== 1'b1) begin n_err++; $display("FAIL ar_async got vld=%b data=%0d rdy=%b exp 0/0/1", vld1, data1, rdy); end
    tick();
    rst_n = 1'b1; rdy1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (vld1 !== 1'b0) begin n_err++; $display("FAIL ar_no_deliver%0d vld1 got %b exp 0", k, vld1); end
    end
    issue(mk(2'b11, 10, 3, 0)); tick();
    vld = 1'b0; tick(); tick();
    n_vec++; if (vld1 !== 1'b1 || data1 !== 8'd15) begin n_err++; $display("FAIL ar_r3_restored got vld=%b data=%0d exp 1/15", vld1, data1); end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hazard();
    test_backpressure();
    test_fill_drain();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
